// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan reader.
package seg7_pkg;

    // Segment patterns {a,b,c,d,e,f,g}, a at bit 6, 1 = lit.
    localparam logic [6:0] PAT_0     = 7'b1111110;
    localparam logic [6:0] PAT_1     = 7'b0110000;
    localparam logic [6:0] PAT_2     = 7'b1101101;
    localparam logic [6:0] PAT_3     = 7'b1111001;
    localparam logic [6:0] PAT_4     = 7'b0110011;
    localparam logic [6:0] PAT_5     = 7'b1011011;
    localparam logic [6:0] PAT_6     = 7'b0011111;
    localparam logic [6:0] PAT_7     = 7'b1110000;
    localparam logic [6:0] PAT_8     = 7'b1111111;
    localparam logic [6:0] PAT_9     = 7'b1110011;
    localparam logic [6:0] BLANK_PAT = 7'b0000000;

    localparam logic [3:0] CODE_BLANK = 4'hA;
    localparam logic [3:0] CODE_ERR   = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StGap,
        StPublish
    } state_t;

endpackage

// File: rtl/seg7_para_bcd.sv
// Combinational decoder from a 7-segment pattern to a BCD code.
module seg7_para_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       invalid
);

    // Table lookup; anything unrecognised becomes CODE_ERR.
    always_comb begin
        code = CODE_ERR;
        case (seg)
            PAT_0:     code = 4'd0;
            PAT_1:     code = 4'd1;
            PAT_2:     code = 4'd2;
            PAT_3:     code = 4'd3;
            PAT_4:     code = 4'd4;
            PAT_5:     code = 4'd5;
            PAT_6:     code = 4'd6;
            PAT_7:     code = 4'd7;
            PAT_8:     code = 4'd8;
            PAT_9:     code = 4'd9;
            BLANK_PAT: code = CODE_BLANK;
            default:   code = CODE_ERR;
        endcase
        // No legal pattern maps to CODE_ERR, so the code doubles as the flag.
        invalid = (code == CODE_ERR);
    end

endmodule

// File: rtl/leitor_7seg.sv
// Reads a multiplexed 4-digit 7-segment scan, debounces each digit and
// publishes complete frames as packed BCD through a valid/ready register.
module leitor_7seg
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,  // legal 2..15
    parameter int unsigned NDIG          = 4   // only 4 is supported
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          seg_in,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic                out_valid,
    output logic                seg_err,
    output logic                overrun,
    output logic                frame_abort
);

    localparam int unsigned     IdxW    = $clog2(NDIG);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NDIG - 1);
    localparam logic [3:0]      CntLast = 4'(STABLE_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [6:0]                seg_prev;
    logic [NDIG-1:0][3:0]      slot_q;
    logic [NDIG-1:0]           slot_err_q;

    logic                      latch_en;
    logic                      publish;
    logic                      abort_d;
    logic [NDIG-1:0]           strobe_cur;
    logic [NDIG-1:0]           strobe_nxt;
    logic [3:0]                dec_code;
    logic                      dec_invalid;

    logic [4*NDIG-1:0]         bcd_d;
    logic                      out_valid_d;
    logic                      seg_err_d;
    logic                      overrun_d;

    seg7_para_bcd u_dec (
        .seg     (seg_in),
        .code    (dec_code),
        .invalid (dec_invalid)
    );

    assign strobe_cur = NDIG'(1) << idx_q;
    assign strobe_nxt = NDIG'(1) << (idx_q + IdxW'(1));

    // Scan sequencing: debounce the strobed digit, then wait for the next strobe.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        publish  = 1'b0;
        abort_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dig_sel == NDIG'(1)) begin
                    state_d = StSettle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (dig_sel == strobe_cur) begin
                    if (seg_in == seg_prev) begin
                        if (cnt_q == CntLast) begin
                            latch_en = 1'b1;
                            cnt_d    = '0;
                            state_d  = (idx_q == IdxLast) ? StPublish : StGap;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end else if (dig_sel == '0) begin
                    // Blanking between refreshes restarts the stability count.
                    cnt_d = '0;
                end else begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (dig_sel == strobe_cur || dig_sel == '0) begin
                    state_d = StGap;
                end else if (dig_sel == strobe_nxt) begin
                    state_d = StSettle;
                    idx_d   = idx_q + IdxW'(1);
                    cnt_d   = '0;
                end else begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            StPublish: begin
                publish = 1'b1;
                state_d = StIdle;
                idx_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: accept drains, publish loads or reports an overrun.
    always_comb begin
        bcd_d       = bcd_out;
        seg_err_d   = seg_err;
        overrun_d   = overrun;
        out_valid_d = out_valid & ~out_ready;
        if (publish) begin
            if (!out_valid || out_ready) begin
                bcd_d       = slot_q;
                seg_err_d   = |slot_err_q;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // FSM, counter and previous-sample registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            seg_prev <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            seg_prev <= seg_in;
        end
    end

    // Per-digit capture slots.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q     <= '0;
            slot_err_q <= '0;
        end else if (latch_en) begin
            slot_q[idx_q]     <= dec_code;
            slot_err_q[idx_q] <= dec_invalid;
        end
    end

    // Published outputs and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_out     <= '0;
            out_valid   <= 1'b0;
            seg_err     <= 1'b0;
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            bcd_out     <= bcd_d;
            out_valid   <= out_valid_d;
            seg_err     <= seg_err_d;
            overrun     <= overrun_d;
            frame_abort <= abort_d;
        end
    end

endmodule

// File: doc/leitor_7seg.md
LEITOR_7SEG -- requirements
Module: leitor_7seg

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical seg_in samples needed to latch a digit; legal range 2..15.
REQ-002 Parameter NDIG, fixed 4: digits per scan frame.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 seg_in  input  7  segment pattern {a,b,c,d,e,f,g}, a at bit 6, active-high (1 = lit).
REQ-006 dig_sel  input  4  active-high digit strobe; one-hot selects digit 0..3; 0000 = blanking.
REQ-007 out_ready  input  1  downstream accepts bcd_out when high with out_valid.
REQ-008 bcd_out  output  16  digit3 in [15:12] down to digit0 in [3:0].
REQ-009 out_valid  output  1  bcd_out holds an unaccepted frame.
REQ-010 seg_err  output  1  the frame in bcd_out contains at least one invalid pattern.
REQ-011 overrun  output  1  sticky: a completed frame was dropped.
REQ-012 frame_abort  output  1  one-cycle pulse: scan sequence violated, partial frame discarded.

Function
REQ-013 Decode table SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 0011111->6, 1110000->7, 1111111->8, 1110011->9, 0000000->4'hA (blank, not an error); any other pattern SHALL yield 4'hF and mark the digit invalid.
REQ-014 seg_prev SHALL register seg_in every cycle.
REQ-015 FSM states: IDLE, SETTLE, GAP, PUBLISH; idx (0..3) SHALL be the digit under capture.
REQ-016 IDLE: on dig_sel==0001, go to SETTLE with idx=0 and cnt=0; otherwise remain in IDLE.
REQ-017 SETTLE: with dig_sel==onehot(idx), cnt SHALL increment when seg_in==seg_prev and clear otherwise; when cnt==STABLE_CYCLES-1 and seg_in==seg_prev, the decoded digit SHALL latch into slot idx.
REQ-018 SETTLE with dig_sel==0000: hold state, clear cnt; any other dig_sel: pulse frame_abort and go to IDLE.
REQ-019 After a latch: idx<3 goes to GAP; idx==3 goes to PUBLISH.
REQ-020 GAP: dig_sel equal to onehot(idx) or 0000 holds GAP; onehot(idx+1) goes to SETTLE with idx+1 and cnt=0; any other value pulses frame_abort and goes to IDLE.
REQ-021 PUBLISH (one cycle, then IDLE): if !out_valid or out_ready, load bcd_out, seg_err (OR of per-digit invalid flags), and set out_valid; else set overrun and keep the existing output.
REQ-022 out_valid SHALL rise on edge E+1, where E is the digit-3 latch edge.
REQ-023 out_valid&&out_ready SHALL clear out_valid on that edge unless PUBLISH reloads it in the same cycle; simultaneous accept and publish yields the new frame with out_valid held high.
REQ-024 bcd_out and seg_err SHALL remain stable while out_valid && !out_ready.
REQ-025 overrun SHALL clear only on reset.
REQ-026 frame_abort SHALL be low in every cycle without a violation; aborts do not change bcd_out, out_valid or seg_err.

Reset
REQ-027 While reset is low: state=IDLE, idx=0, cnt=0, seg_prev=0, digit slots=0, bcd_out=16'h0000, out_valid=0, seg_err=0, overrun=0, frame_abort=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, capture restarts only on a fresh dig_sel==0001.

Structure
REQ-029 Package seg7_pkg SHALL hold the ten digit pattern constants, BLANK_PAT, CODE_BLANK=4'hA, CODE_ERR=4'hF, and the FSM state enum.
REQ-030 Sub-module seg7_para_bcd (combinational) SHALL implement the REQ-013 table and output code[3:0] and invalid.

Verification
REQ-031 Scan 1,2,3,4 (patterns 0110000, 1101101, 1111001, 0110011), each held 6 cycles with 1-cycle 0000 gaps, out_ready=1 -> bcd_out=16'h4321, out_valid for 1 cycle, seg_err=0.
REQ-032 Digit 1 pattern toggles every 2 cycles for 10 cycles, then settles on 1111111 -> latches only after 4 stable samples; bcd_out[7:4]=8.
REQ-033 Digit 2 pattern 1010101 -> bcd_out[11:8]=4'hF, seg_err=1; digit 0 = 0000000 -> nibble 4'hA, no error from it.
REQ-034 dig_sel jumps 0001 to 0100 -> frame_abort pulse, state IDLE, bcd_out unchanged.
REQ-035 Two full frames with out_ready=0 -> first frame held, overrun=1; raising out_ready -> out_valid drops next edge, overrun stays 1.
REQ-036 reset low during digit 2 SETTLE -> all outputs 0; a new complete frame afterwards publishes correctly.
